// File: rtl/ped_signal_ctrl.sv
// Pedestrian-crossing controller slaved to the vehicle light: tracks the vehicle red
// phase, debounces the request button and sequences pedestrian WALK / FLASH / RED.
module ped_signal_ctrl #(
    parameter int WALK_TICKS   = 10,
    parameter int FLASH_TICKS  = 3,
    parameter int DEBOUNCE_CYC = 16,
    parameter int AUTO_WALK    = 0,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick_i,
    input  logic [2:0] veh_color_i,
    input  logic       btn_i,
    output logic [1:0] ped_color_o,
    output logic       wait_lamp_o,
    output logic       buzzer_o
);

    typedef enum logic [1:0] {P_RED, P_WALK, P_FLASH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               blink_q, blink_d;
    logic               red_phase_q, red_phase_d, red_onset;
    logic [1:0]         sync_q;
    logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
    logic               btn_db_q, btn_db_d, btn_db_dly_q, press;
    logic               req_pending_q, req_pending_d;
    logic [1:0]         ped_color_q, ped_color_d;
    logic               buzzer_q, buzzer_d;

    // Dark lamps (blink-off or disabled light) keep the last phase; any yellow/green bit drops it.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        red_phase_d = red_phase_q;
        if (veh_color_i[1:0] != 2'b00) red_phase_d = 1'b0;
        else if (veh_color_i[2])       red_phase_d = 1'b1;
    end

    assign red_onset = red_phase_d & ~red_phase_q;

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (sync_q[1] != btn_db_q) begin
            if (db_cnt_q >= CNT_W'(DEBOUNCE_CYC - 1)) begin
                btn_db_d = sync_q[1];
            end else if (db_cnt_q != '1) begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end else begin
                db_cnt_d = db_cnt_q;
            end
        end
    end

    assign press   = btn_db_q & ~btn_db_dly_q;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        blink_d       = blink_q;
        req_pending_d = req_pending_q;
        case (state_q)
            P_RED: begin
                if (red_onset && (req_pending_q || press || AUTO_WALK != 0)) begin
                    state_d       = P_WALK;
                    cnt_d         = '0;
                    req_pending_d = 1'b0;
                end else if (press) begin
                    req_pending_d = 1'b1;
                end
            end
            P_WALK: begin
                if (!red_phase_d) begin
                    state_d = P_RED;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == CNT_W'(WALK_TICKS - 1)) begin
                        state_d = P_FLASH;
                        cnt_d   = '0;
                        blink_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            P_FLASH: begin
                if (!red_phase_d) begin
                    state_d = P_RED;
                    cnt_d   = '0;
                    blink_d = 1'b0;
                end else if (tick_i) begin
                    if (cnt_q == CNT_W'(2 * FLASH_TICKS - 1)) begin
                        state_d = P_RED;
                        cnt_d   = '0;
                        blink_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_inc;
                        blink_d = ~blink_q;
                    end
                end
            end
            default: begin
                state_d = P_RED;
                cnt_d   = '0;
                blink_d = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the triggering edge.
    always_comb begin
        case (state_d)
            P_WALK:  ped_color_d = 2'b01;
            P_FLASH: ped_color_d = {1'b0, blink_d};
            default: ped_color_d = 2'b10;
        endcase
        buzzer_d = tick_i & red_phase_d & (state_q != P_RED);
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= P_RED;
            cnt_q         <= '0;
            blink_q       <= 1'b0;
            red_phase_q   <= 1'b0;
            sync_q        <= 2'b00;
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            btn_db_dly_q  <= 1'b0;
            req_pending_q <= 1'b0;
            ped_color_q   <= 2'b10;
            buzzer_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            blink_q       <= blink_d;
            red_phase_q   <= red_phase_d;
            sync_q        <= {sync_q[0], btn_i};
            db_cnt_q      <= db_cnt_d;
            btn_db_q      <= btn_db_d;
            btn_db_dly_q  <= btn_db_q;
            req_pending_q <= req_pending_d;
            ped_color_q   <= ped_color_d;
            buzzer_q      <= buzzer_d;
        end
    end

    assign ped_color_o = ped_color_q;
    assign wait_lamp_o = req_pending_q;
    assign buzzer_o    = buzzer_q;

endmodule

// File: doc/ped_signal_ctrl.md
Name: ped_signal_ctrl

Overview:
Pedestrian-crossing controller that sits directly downstream of the vehicle traffic light. It consumes the light's one-hot lamp vector, `veh_color_i`, and the same step-enable tick that drives it. It grants a pedestrian WALK phase only while the vehicle RED phase is active. It also debounces the pedestrian request button, drives the request-acknowledge lamp, and drives an audible-cue pulse.

Parameters:
WALK_TICKS, 10, ticks of steady pedestrian green (>=1)
FLASH_TICKS, 3, number of pedestrian-green blink periods after WALK; each period is 2 ticks (>=1)
DEBOUNCE_CYC, 16, consecutive clk cycles the synchronized button must be stable before it is accepted (>=2)
AUTO_WALK, 0, 1 = grant WALK on every vehicle red phase even without a request
CNT_W, 8, width of the tick and debounce counters

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
tick_i  input  1  one-clk step enable; same pulse that steps the vehicle light
veh_color_i  input  3  vehicle lamps: [2] RED, [1] YELLOW, [0] GREEN; blinks and goes dark when the vehicle light is disabled
btn_i  input  1  pedestrian button, asynchronous, active-high
ped_color_o  output  2  [1] pedestrian RED, [0] pedestrian GREEN; registered
wait_lamp_o  output  1  request-registered indicator; registered
buzzer_o  output  1  one-clk audible pulse per tick during WALK/FLASH; registered

Behaviour:
- Reset (rstn=0 at a clk edge) forces the following, regardless of any mid-operation state:
  - state=P_RED, ped_color_o=2'b10, wait_lamp_o=0, buzzer_o=0.
  - Counters=0, req_pending=0, red_phase=0, sync/debounce flops=0.
- Vehicle phase tracking (register red_phase):
  - veh_color_i==3'b100 sets red_phase.
  - Any of veh_color_i[1:0] set clears red_phase.
  - 3'b000 (blink-off or disabled) holds the previous value.
  - Any other multi-hot pattern clears red_phase (fail-safe).
- red_onset = next_red_phase & ~red_phase, evaluated combinationally each clk.
- Button path:
  - 2-FF synchronizer, then the debounce counter.
  - btn_db changes only after the synchronized level differs from btn_db for DEBOUNCE_CYC consecutive clks; any bounce resets the counter.
  - press = btn_db rising edge (1 clk).
  - press in P_RED sets req_pending; press in P_WALK/P_FLASH is ignored.
  - wait_lamp_o = req_pending, registered.
- FSM:
  - P_RED: ped_color_o=10.
    - If red_onset and (req_pending | press | AUTO_WALK): go to P_WALK, cnt=0, req_pending cleared.
    - WALK starts only at red onset, never mid-phase. A request arriving mid-phase waits for the next red phase.
  - P_WALK: ped_color_o=01.
    - Each tick_i: cnt+1.
    - On the tick where cnt==WALK_TICKS-1: go to P_FLASH, cnt=0, green off.
  - P_FLASH: ped_color_o[1]=0, ped_color_o[0]=blink bit.
    - Each tick_i: blink toggles, cnt+1.
    - On the tick where cnt==2*FLASH_TICKS-1: go to P_RED with ped_color_o=10.
  - Abort: in P_WALK or P_FLASH, next_red_phase==0 causes P_RED on that same edge. Abort has priority over a simultaneous tick.
- Latency:
  - ped_color_o reflects the new state on the clk edge that samples the triggering veh_color_i/tick_i, i.e. one cycle after the input is presented.
  - Button-to-wait_lamp_o latency: 2 + DEBOUNCE_CYC + 1 clks.
- buzzer_o=1 for exactly the clk after each tick_i sampled in P_WALK or P_FLASH, and 0 otherwise.
- Counters saturate at all-ones; they never wrap.
- Pedestrian green and red are never both 1. ped_color_o is never 00 outside P_FLASH-off.

Test Plan:
1. Reset mid-WALK: rstn=0 for 1 clk with state=P_WALK, cnt=5 -> next cycle ped_color_o=10, wait_lamp_o=0, buzzer_o=0.
2. Button held 20 clks, then veh_color_i goes 001->010->100 (defaults):
   - wait_lamp_o rises 19 clks after the press and clears on red onset.
   - ped_color_o=01 for 10 ticks, then 00/01 alternating for 6 ticks, then 10.
3. Button bounce of 1-clk pulses every 5 clks for 40 clks -> wait_lamp_o stays 0; no WALK on the next red onset with AUTO_WALK=0.
4. Request pending, vehicle red blinking 100/000 with the light disabled mid-WALK -> WALK continues, because 000 holds red_phase.
5. veh_color_i switches 100->010 at WALK tick 4, coincident with tick_i -> ped_color_o=10 on the next cycle; buzzer_o stays 0 from then on.
6. AUTO_WALK=1, no button, two red phases -> two full WALK/FLASH sequences. Press during WALK is ignored: wait_lamp_o stays 0.
